serial_alu_seq: RTL

Bit-serial ALU sequencer: accepts a WIDTH-bit operation in one cycle, then drives a single 1-bit ALU slice LSB-first for WIDTH cycles, feeding each bit's carry back in as the next bit's carry-in. It assembles the result bits into a word and reports completion with a one-cycle `done` pulse. It is the word-level driver and collector for the 1-bit ALU slice: it produces the per-bit A/B/carry-in/select stimulus and consumes the slice's out/carryout, so multi-bit arithmetic runs on one slice.

---
 rtl/serial_alu_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: runs one 1-bit ALU slice LSB-first for WIDTH cycles and collects the result word.
// Optional SERIAL_ALU_FLAGS_EN builds the overflow and zero flag registers; otherwise both outputs are tied to 0.
module serial_alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_ADD  = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-2:0] sr_q, sr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carryout_q, carryout_d;

   // 1-bit slice; B is inverted for SUB/SLT so subtraction is A + ~B + 1.
   logic is_arith, invert_b, a_bit, b_bit, slice_sum, slice_cout, slice_out;
   logic last_bit, ovf, final_carry;
   logic [WIDTH-1:0] word, final_result;

   assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
   assign invert_b   = (op_q == OP_SUB) || (op_q == OP_SLT);
   assign a_bit      = a_q[cnt_q];
   assign b_bit      = b_q[cnt_q] ^ invert_b;
   assign slice_sum  = a_bit ^ b_bit ^ carry_q;
   assign slice_cout = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

   always_comb begin
      case (op_q)
         OP_AND:  slice_out = a_bit & b_bit;
         OP_OR:   slice_out = a_bit | b_bit;
         OP_XOR:  slice_out = a_bit ^ b_bit;
         OP_NAND: slice_out = ~(a_bit & b_bit);
         OP_NOR:  slice_out = ~(a_bit | b_bit);
         default: slice_out = slice_sum;
      endcase
   end

   // On the last bit, carry_q is the carry into the MSB, so ovf is the signed overflow term.
   assign last_bit     = (cnt_q == CNT_W'(WIDTH - 1));
   assign word         = {slice_out, sr_q};
   assign ovf          = carry_q ^ slice_cout;
   assign final_carry  = is_arith ? slice_cout : 1'b0;
   assign final_result = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slice_sum ^ ovf} : word;

   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      carry_d    = carry_q;
      sr_d       = sr_q;
      result_d   = result_q;
      carryout_d = carryout_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               cnt_d   = '0;
               carry_d = (op == OP_SUB) || (op == OP_SLT);
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            sr_d    = word[WIDTH-1:1];
            carry_d = is_arith ? slice_cout : 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               result_d   = final_result;
               carryout_d = final_carry;
               state_d    = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state, including the operand latches and shift register, is reset so nothing from an aborted op survives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         sr_q       <= '0;
         result_q   <= '0;
         carryout_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         carry_q    <= carry_d;
         sr_q       <= sr_d;
         result_q   <= result_d;
         carryout_q <= carryout_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign carryout = carryout_q;

`ifdef SERIAL_ALU_FLAGS_EN
   logic overflow_q, overflow_d, zero_q, zero_d;
   logic enter_done;

   assign enter_done = (state_q == S_SHIFT) && last_bit;

   always_comb begin
      overflow_d = overflow_q;
      zero_d     = zero_q;
      if (enter_done) begin
         overflow_d = is_arith ? ovf : 1'b0;
         zero_d     = (final_result == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
         zero_q     <= zero_d;
      end
   end

   assign overflow = overflow_q;
   assign zero     = zero_q;
`else
   assign overflow = 1'b0;
   assign zero     = 1'b0;
`endif

endmodule
